// File: rtl/unidade_controle_jogo.sv
// Control FSM for the FPGAudio game: menu pages, listen-then-repeat rounds and the end-of-game outcome.
// Moore strobes are registered from the next state; only the menu capture strobes are Mealy on confirma.
module unidade_controle_jogo #(
    parameter int NUM_MENUS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       confirma,
    input  logic       nota_feita,
    input  logic       nota_correta,
    input  logic       enderecoIgualRodada,
    input  logic       fimTF,
    input  logic       fimTempo,
    input  logic       fimCR,
    input  logic       fim_musica,
    output logic       zeraR,
    output logic       registraR,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraCR,
    output logic       contaCR,
    output logic       zeraTF,
    output logic       contaTF,
    output logic       zeraTempo,
    output logic       contaTempo,
    output logic       zeraMetro,
    output logic       contaMetro,
    output logic       leds_mem,
    output logic       ativa_leds,
    output logic       toca,
    output logic       inicia_menu,
    output logic [1:0] menu_sel,
    output logic       registra_modo,
    output logic       registra_bpm,
    output logic       registra_musicas,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [4:0] db_estado
);

    typedef enum logic [4:0] {
        INICIAL     = 5'd0,
        MENU_MODO   = 5'd1,
        MENU_BPM    = 5'd2,
        MENU_MUSICA = 5'd3,
        PREPARA     = 5'd4,
        MOSTRA      = 5'd5,
        PROX_MOSTRA = 5'd6,
        ZERA_END    = 5'd7,
        ESPERA      = 5'd8,
        REGISTRA    = 5'd9,
        FEEDBACK    = 5'd10,
        COMPARA     = 5'd11,
        PROX_NOTA   = 5'd12,
        PROX_RODADA = 5'd13,
        ACERTOU_ST  = 5'd14,
        ERROU_ST    = 5'd15,
        TIMEOUT_ST  = 5'd16
    } state_t;

    typedef struct packed {
        logic       zera_r;
        logic       registra_r;
        logic       zera_c;
        logic       conta_c;
        logic       zera_cr;
        logic       conta_cr;
        logic       zera_tf;
        logic       conta_tf;
        logic       zera_tempo;
        logic       conta_tempo;
        logic       zera_metro;
        logic       conta_metro;
        logic       leds_mem;
        logic       ativa_leds;
        logic       toca;
        logic       inicia_menu;
        logic [1:0] menu_sel;
        logic       pronto;
        logic       acertou;
        logic       errou;
        logic       timeout;
    } moore_t;

    localparam logic [4:0] ULTIMO_MENU = 5'(MENU_MODO) + 5'(NUM_MENUS - 1);

    state_t state_q, state_d;
    moore_t out_q;

    function automatic moore_t decode(input state_t s);
        moore_t o;
        o = '0;
        case (s)
            INICIAL:     begin o.inicia_menu = 1'b1; o.zera_r = 1'b1; end
            MENU_MODO, MENU_BPM, MENU_MUSICA:
                         o.menu_sel = 2'(s - MENU_MODO);
            PREPARA:     begin
                             o.zera_c = 1'b1; o.zera_cr = 1'b1; o.zera_r = 1'b1;
                             o.zera_tf = 1'b1; o.zera_tempo = 1'b1; o.zera_metro = 1'b1;
                         end
            MOSTRA:      begin
                             o.leds_mem = 1'b1; o.ativa_leds = 1'b1; o.toca = 1'b1;
                             o.conta_tf = 1'b1; o.conta_metro = 1'b1;
                         end
            PROX_MOSTRA: begin o.conta_c = 1'b1; o.zera_tf = 1'b1; end
            ZERA_END:    begin
                             o.zera_c = 1'b1; o.zera_tempo = 1'b1; o.zera_tf = 1'b1; o.zera_r = 1'b1;
                         end
            ESPERA:      o.conta_tempo = 1'b1;
            REGISTRA:    begin o.registra_r = 1'b1; o.zera_tf = 1'b1; end
            FEEDBACK:    begin o.ativa_leds = 1'b1; o.toca = 1'b1; o.conta_tf = 1'b1; end
            PROX_NOTA:   begin o.conta_c = 1'b1; o.zera_tempo = 1'b1; end
            PROX_RODADA: begin
                             o.conta_cr = 1'b1; o.zera_c = 1'b1; o.zera_tf = 1'b1; o.zera_metro = 1'b1;
                         end
            ACERTOU_ST:  begin o.acertou = 1'b1; o.pronto = 1'b1; end
            ERROU_ST:    begin o.errou = 1'b1; o.pronto = 1'b1; end
            TIMEOUT_ST:  begin o.timeout = 1'b1; o.pronto = 1'b1; end
            default:     o = '0;
        endcase
        return o;
    endfunction

    always_comb begin
        // NOTE: hold-by-default assignment first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            INICIAL:     if (iniciar) state_d = MENU_MODO;
            MENU_MODO, MENU_BPM, MENU_MUSICA:
                         if (confirma)
                             state_d = (state_q == ULTIMO_MENU) ? PREPARA : state_t'(state_q + 5'd1);
            PREPARA:     state_d = MOSTRA;
            MOSTRA:      if (fimTF) state_d = enderecoIgualRodada ? ZERA_END : PROX_MOSTRA;
            PROX_MOSTRA: state_d = MOSTRA;
            ZERA_END:    state_d = ESPERA;
            ESPERA:      if (nota_feita)    state_d = REGISTRA;
                         else if (fimTempo) state_d = TIMEOUT_ST;
            REGISTRA:    state_d = FEEDBACK;
            // Feedback lasts until the timer expires and the key is released.
            FEEDBACK:    if (fimTF && !nota_feita) state_d = COMPARA;
            COMPARA:     if (!nota_correta)             state_d = ERROU_ST;
                         else if (!enderecoIgualRodada) state_d = PROX_NOTA;
                         else if (fim_musica || fimCR)  state_d = ACERTOU_ST;
                         else                           state_d = PROX_RODADA;
            PROX_NOTA:   state_d = ESPERA;
            PROX_RODADA: state_d = MOSTRA;
            ACERTOU_ST, ERROU_ST, TIMEOUT_ST:
                         if (iniciar) state_d = PREPARA;
            default:     state_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= INICIAL;
            out_q   <= decode(INICIAL);
        end else begin
            state_q <= state_d;
            out_q   <= decode(state_d);
        end
    end

    assign zeraR       = out_q.zera_r;
    assign registraR   = out_q.registra_r;
    assign zeraC       = out_q.zera_c;
    assign contaC      = out_q.conta_c;
    assign zeraCR      = out_q.zera_cr;
    assign contaCR     = out_q.conta_cr;
    assign zeraTF      = out_q.zera_tf;
    assign contaTF     = out_q.conta_tf;
    assign zeraTempo   = out_q.zera_tempo;
    assign contaTempo  = out_q.conta_tempo;
    assign zeraMetro   = out_q.zera_metro;
    assign contaMetro  = out_q.conta_metro;
    assign leds_mem    = out_q.leds_mem;
    assign ativa_leds  = out_q.ativa_leds;
    assign toca        = out_q.toca;
    assign inicia_menu = out_q.inicia_menu;
    assign menu_sel    = out_q.menu_sel;
    assign pronto      = out_q.pronto;
    assign acertou     = out_q.acertou;
    assign errou       = out_q.errou;
    assign timeout     = out_q.timeout;
    assign db_estado   = state_q;

    // Menu captures fire in the same cycle as confirma, before the page advances.
    assign registra_modo    = (state_q == MENU_MODO)   && confirma;
    assign registra_bpm     = (state_q == MENU_BPM)    && confirma;
    assign registra_musicas = (state_q == MENU_MUSICA) && confirma;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Bench for unidade_controle_jogo: vector table, menu pulse sequence and a randomized run
// against a state-table reference model.
module tb_unidade_controle_jogo;

    logic clk = 1'b0;
    logic reset, iniciar, confirma, nota_feita, nota_correta, enderecoIgualRodada;
    logic fimTF, fimTempo, fimCR, fim_musica;
    logic zeraR, registraR, zeraC, contaC, zeraCR, contaCR, zeraTF, contaTF;
    logic zeraTempo, contaTempo, zeraMetro, contaMetro, leds_mem, ativa_leds, toca, inicia_menu;
    logic [1:0] menu_sel;
    logic registra_modo, registra_bpm, registra_musicas, pronto, acertou, errou, timeout;
    logic [4:0] db_estado;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    unidade_controle_jogo #(.NUM_MENUS(3)) dut (
        .clock(clk), .reset(reset), .iniciar(iniciar), .confirma(confirma),
        .nota_feita(nota_feita), .nota_correta(nota_correta),
        .enderecoIgualRodada(enderecoIgualRodada), .fimTF(fimTF), .fimTempo(fimTempo),
        .fimCR(fimCR), .fim_musica(fim_musica),
        .zeraR(zeraR), .registraR(registraR), .zeraC(zeraC), .contaC(contaC),
        .zeraCR(zeraCR), .contaCR(contaCR), .zeraTF(zeraTF), .contaTF(contaTF),
        .zeraTempo(zeraTempo), .contaTempo(contaTempo), .zeraMetro(zeraMetro),
        .contaMetro(contaMetro), .leds_mem(leds_mem), .ativa_leds(ativa_leds), .toca(toca),
        .inicia_menu(inicia_menu), .menu_sel(menu_sel), .registra_modo(registra_modo),
        .registra_bpm(registra_bpm), .registra_musicas(registra_musicas), .pronto(pronto),
        .acertou(acertou), .errou(errou), .timeout(timeout), .db_estado(db_estado)
    );

    // Output bit positions in the comparison vector.
    localparam int O_ZR = 0, O_RR = 1, O_ZC = 2, O_CC = 3, O_ZCR = 4, O_CCR = 5, O_ZTF = 6;
    localparam int O_CTF = 7, O_ZT = 8, O_CT = 9, O_ZM = 10, O_CM = 11, O_LM = 12, O_AL = 13;
    localparam int O_TOCA = 14, O_IM = 15, O_RMODO = 16, O_RBPM = 17, O_RMUS = 18;
    localparam int O_PRONTO = 19, O_ACERTOU = 20, O_ERROU = 21, O_TIMEOUT = 22;

    // Input bundle bits.
    typedef logic [9:0] in_t;
    localparam in_t RST = 10'b1000000000, INI = 10'b0100000000, CONF = 10'b0010000000;
    localparam in_t NF  = 10'b0001000000, NC  = 10'b0000100000, EIG  = 10'b0000010000;
    localparam in_t FTF = 10'b0000001000, FTEMPO = 10'b0000000100;
    localparam in_t FCR = 10'b0000000010, FMUS = 10'b0000000001;
    localparam in_t NONE = 10'b0;

    typedef struct {
        in_t in;
        int  exp_state;
    } vec_t;

    logic [22:0] mask [0:31];
    vec_t tbl [$];

    function automatic logic [22:0] b(input int p);
        return 23'(1) << p;
    endfunction

    function automatic logic [29:0] dut_vec();
        return {db_estado, menu_sel, timeout, errou, acertou, pronto, registra_musicas,
                registra_bpm, registra_modo, inicia_menu, toca, ativa_leds, leds_mem,
                contaMetro, zeraMetro, contaTempo, zeraTempo, contaTF, zeraTF, contaCR,
                zeraCR, contaC, zeraC, registraR, zeraR};
    endfunction

    function automatic logic [29:0] exp_vec(input int s, input logic conf);
        logic [22:0] o;
        logic [1:0]  page;
        o = mask[s];
        page = 2'd0;
        if (s >= 1 && s <= 3) begin
            page = 2'(s - 1);
            if (conf) o = o | b(O_RMODO + s - 1);
        end
        return {5'(s), page, o};
    endfunction

    // Reference next state, written straight from the game rules.
    function automatic int ref_next(input int s, input in_t x);
        if (x[9]) return 0;
        case (s)
            0:       return x[8] ? 1 : 0;
            1, 2:    return x[7] ? s + 1 : s;
            3:       return x[7] ? 4 : 3;
            4:       return 5;
            5:       return x[3] ? (x[4] ? 7 : 6) : 5;
            6:       return 5;
            7:       return 8;
            8:       return x[6] ? 9 : (x[2] ? 16 : 8);
            9:       return 10;
            10:      return (x[3] && !x[6]) ? 11 : 10;
            11:      begin
                         if (!x[5]) return 15;
                         if (!x[4]) return 12;
                         if (x[0] || x[1]) return 14;
                         return 13;
                     end
            12:      return 8;
            13:      return 5;
            14, 15, 16: return x[8] ? 4 : s;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input in_t x);
        reset = x[9]; iniciar = x[8]; confirma = x[7]; nota_feita = x[6];
        nota_correta = x[5]; enderecoIgualRodada = x[4]; fimTF = x[3];
        fimTempo = x[2]; fimCR = x[1]; fim_musica = x[0];
    endtask

    task automatic add(input in_t x, input int s);
        vec_t v;
        v.in = x;
        v.exp_state = s;
        tbl.push_back(v);
    endtask

    initial begin
        int cur;
        int cnt_m, cnt_b, cnt_s, at_m, at_b, at_s;

        for (int i = 0; i < 32; i++) mask[i] = '0;
        mask[0]  = b(O_IM) | b(O_ZR);
        mask[4]  = b(O_ZC) | b(O_ZCR) | b(O_ZR) | b(O_ZTF) | b(O_ZT) | b(O_ZM);
        mask[5]  = b(O_LM) | b(O_AL) | b(O_TOCA) | b(O_CTF) | b(O_CM);
        mask[6]  = b(O_CC) | b(O_ZTF);
        mask[7]  = b(O_ZC) | b(O_ZT) | b(O_ZTF) | b(O_ZR);
        mask[8]  = b(O_CT);
        mask[9]  = b(O_RR) | b(O_ZTF);
        mask[10] = b(O_AL) | b(O_TOCA) | b(O_CTF);
        mask[12] = b(O_CC) | b(O_ZT);
        mask[13] = b(O_CCR) | b(O_ZC) | b(O_ZTF) | b(O_ZM);
        mask[14] = b(O_ACERTOU) | b(O_PRONTO);
        mask[15] = b(O_ERROU) | b(O_PRONTO);
        mask[16] = b(O_TIMEOUT) | b(O_PRONTO);

        // Menu, round 0 correct, stall on held key, extra note, timeout, restart.
        add(RST, 0);   add(INI, 1);  add(INI, 1);   add(CONF, 2);  add(NONE, 2);
        add(CONF, 3);  add(CONF | INI, 4); add(NONE, 5); add(EIG, 5); add(FTF | EIG, 7);
        add(NONE, 8);  add(NF | FTEMPO, 9); add(NF, 10); add(FTF | NF, 10); add(FTF, 11);
        add(NC | EIG, 13); add(NONE, 5); add(FTF, 6); add(CONF, 5); add(FTF | EIG, 7);
        add(NONE, 8);  add(NONE, 8); add(FTEMPO, 16); add(CONF, 16); add(INI, 4);
        // Two-note round ending on the last note of the song.
        add(NONE, 5);  add(FTF | EIG, 7); add(NONE, 8); add(NF, 9); add(NONE, 10);
        add(FTF, 11);  add(NC, 12); add(NONE, 8); add(NF, 9); add(NONE, 10);
        add(FTF, 11);  add(NC | EIG | FMUS | FCR, 14); add(NONE, 14); add(INI, 4);
        // Reset in the middle of feedback.
        add(NONE, 5);  add(FTF | EIG, 7); add(NONE, 8); add(NF, 9); add(FTF, 10);
        add(NF, 10);   add(RST | NF, 0); add(NONE, 0);
        // Wrong note, then restart with the same settings.
        add(INI, 1);   add(CONF, 2); add(CONF, 3); add(CONF, 4); add(NONE, 5);
        add(FTF | EIG, 7); add(NONE, 8); add(NF, 9); add(NONE, 10); add(FTF, 11);
        add(EIG, 15);  add(NONE, 15); add(INI, 4); add(NONE, 5);

        apply(RST);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(dut_vec()), 32'(exp_vec(0, 1'b0)));

        cur = 0;
        foreach (tbl[i]) begin
            apply(tbl[i].in);
            @(negedge clk);
            check($sformatf("vec%0d_out", i), 32'(dut_vec()), 32'(exp_vec(cur, tbl[i].in[7])));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_state", i), 32'(db_estado), 32'(tbl[i].exp_state));
            cur = tbl[i].exp_state;
        end

        // Menu: three confirma pulses four cycles apart.
        apply(RST);
        @(posedge clk); #1;
        apply(INI);
        @(posedge clk); #1;
        cnt_m = 0; cnt_b = 0; cnt_s = 0; at_m = -1; at_b = -1; at_s = -1;
        for (int c = 0; c < 12; c++) begin
            apply((c % 4 == 0 && c < 12) ? CONF : NONE);
            @(negedge clk);
            if (registra_modo)    begin cnt_m++; at_m = c; end
            if (registra_bpm)     begin cnt_b++; at_b = c; end
            if (registra_musicas) begin cnt_s++; at_s = c; end
            if (c == 0) check("menu_sel_p0", 32'(menu_sel), 32'd0);
            if (c == 4) check("menu_sel_p1", 32'(menu_sel), 32'd1);
            if (c == 8) check("menu_sel_p2", 32'(menu_sel), 32'd2);
            if (c == 9) check("menu_sel_after", 32'(menu_sel), 32'd0);
            if (c == 10) check("mostra_after_menu", 32'(db_estado), 32'd5);
            @(posedge clk); #1;
        end
        check("reg_modo_pulses", 32'(cnt_m), 32'd1);
        check("reg_bpm_pulses", 32'(cnt_b), 32'd1);
        check("reg_mus_pulses", 32'(cnt_s), 32'd1);
        check("reg_order", 32'((at_m == 0) && (at_b == 4) && (at_s == 8)), 32'd1);

        // Randomized run against the reference model.
        apply(RST);
        @(posedge clk); #1;
        cur = 0;
        for (int n = 0; n < 4000; n++) begin
            in_t x;
            x = NONE;
            if ($urandom_range(0, 149) == 0) x |= RST;
            if ($urandom_range(0, 5) == 0)   x |= INI;
            if ($urandom_range(0, 3) == 0)   x |= CONF;
            if ($urandom_range(0, 3) == 0)   x |= NF;
            if ($urandom_range(0, 3) != 0)   x |= NC;
            if ($urandom_range(0, 1) == 0)   x |= EIG;
            if ($urandom_range(0, 2) == 0)   x |= FTF;
            if ($urandom_range(0, 9) == 0)   x |= FTEMPO;
            if ($urandom_range(0, 7) == 0)   x |= FCR;
            if ($urandom_range(0, 7) == 0)   x |= FMUS;
            apply(x);
            @(negedge clk);
            check($sformatf("rand%0d_out", n), 32'(dut_vec()), 32'(exp_vec(cur, x[7])));
            @(posedge clk); #1;
            cur = ref_next(cur, x);
        end
        @(negedge clk);
        check("rand_final_state", 32'(db_estado), 32'(cur));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
